// File: rtl/rf_pkg.sv
// Shared register-file definitions.
// Holds the clear/run state encoding, the default data and address widths
// (also used by the decode and hazard units), and a helper that gives the
// first register index the clear sweep touches.
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   // Register 0 never needs clearing when it is hard-wired to zero.
   function automatic int rf_sweep_start(input bit zero_reg);
      return zero_reg ? 1 : 0;
   endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer for the multi-port register file.
// Owns the CLEAR/RUN state machine, the sweep index and the Ready flag.
// All state changes on the falling clock edge.
// Ports:
//   i_clk        clock (falling edge active)
//   i_rst_n      synchronous active-low reset, restarts the sweep
//   i_clear_req  request a new sweep (only honoured in RUN)
//   o_clr_we     write zero to o_clr_addr at the coming edge
//   o_clr_addr   register being cleared this cycle
//   o_ready      1 = sweep finished, file accepts writes and reads
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear_req,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr,
   output logic              o_ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   // Index carries one extra bit so the terminal compare cannot wrap.
   localparam logic [ADDR_W:0] START = (ADDR_W + 1)'(rf_sweep_start(ZERO_REG));
   localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

   rf_state_e         r_state;
   rf_state_e         w_state_nxt;
   logic [ADDR_W:0]   r_idx;
   logic [ADDR_W:0]   w_idx_nxt;
   logic              r_ready;

   // Next-state and sweep-index logic.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         RF_CLEAR: begin
            w_idx_nxt = r_idx + ONE;
            if (r_idx == LAST) begin
               w_state_nxt = RF_RUN;
            end else begin
               w_state_nxt = RF_CLEAR;
            end
         end
         RF_RUN: begin
            if (i_clear_req) begin
               w_state_nxt = RF_CLEAR;
               w_idx_nxt   = START;
            end else begin
               w_state_nxt = RF_RUN;
               w_idx_nxt   = r_idx;
            end
         end
         default: begin
            w_state_nxt = RF_CLEAR;
            w_idx_nxt   = START;
         end
      endcase
   end

   // State, index and Ready registers; reset overrides everything.
   always_ff @(negedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= RF_CLEAR;
         r_idx   <= START;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ready <= (w_state_nxt == RF_RUN);
      end
   end

   // No clear write on a reset edge: reset wins over the sweep.
   assign o_clr_we   = (r_state == RF_CLEAR) && i_rst_n;
   assign o_clr_addr = r_idx[ADDR_W-1:0];
   assign o_ready    = r_ready;

endmodule

// File: rtl/multi_port_reg_file.sv
// Multi-port general-purpose register file for the decode stage.
// Two prioritised write ports (port 1 wins), NUM_RD combinational read ports
// with optional write-through bypass, optional hard-zero register 0, and a
// sequenced clear sweep after reset or on request. State updates on the
// falling edge of CLK.
// Ports:
//   CLK, RST               clock (falling edge) and synchronous active-low reset
//   ClearReq               re-run the clear sweep (RUN only)
//   RegWreN/WriteRegN/WriteDataN  write port N enable/address/data
//   ReadReg / ReadData     packed read addresses / data, port k in slice k
//   Ready                  file initialised and accepting writes
module multi_port_reg_file
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ClearReq,
   input  logic                     RegWre0,
   input  logic [ADDR_W-1:0]        WriteReg0,
   input  logic [DATA_W-1:0]        WriteData0,
   input  logic                     RegWre1,
   input  logic [ADDR_W-1:0]        WriteReg1,
   input  logic [DATA_W-1:0]        WriteData1,
   input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
   output logic [NUM_RD*DATA_W-1:0] ReadData,
   output logic                     Ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_ready;
   logic              w_wr_ok;
   logic              w_we0;
   logic              w_we1;

   rf_clear_seq #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_clear_seq (
      .i_clk       (CLK),
      .i_rst_n     (RST),
      .i_clear_req (ClearReq),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr),
      .o_ready     (w_ready)
   );

   // User writes only in RUN, not on a reset edge, and not on the edge that starts a clear.
   assign w_wr_ok = w_ready && RST && !ClearReq;
   assign w_we0   = RegWre0 && w_wr_ok && !(ZERO_REG && (WriteReg0 == ADDR_ZERO));
   assign w_we1   = RegWre1 && w_wr_ok && !(ZERO_REG && (WriteReg1 == ADDR_ZERO));

   // Storage write mux; port 1 is assigned last so it wins on an address collision.
   always_ff @(negedge CLK) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= DATA_ZERO;
      end else begin
         if (w_we0) begin
            r_mem[WriteReg0] <= WriteData0;
         end
         if (w_we1) begin
            r_mem[WriteReg1] <= WriteData1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;

      assign w_addr = ReadReg[k*ADDR_W +: ADDR_W];

      // Read/bypass mux; zero check precedes bypass so address 0 is never forwarded.
      always_comb begin
         w_data = DATA_ZERO;
         if (!w_ready) begin
            w_data = DATA_ZERO;
         end else if (ZERO_REG && (w_addr == ADDR_ZERO)) begin
            w_data = DATA_ZERO;
         end else if (BYPASS && RegWre1 && (WriteReg1 == w_addr)) begin
            w_data = WriteData1;
         end else if (BYPASS && RegWre0 && (WriteReg0 == w_addr)) begin
            w_data = WriteData0;
         end else begin
            w_data = r_mem[w_addr];
         end
      end

      assign ReadData[k*DATA_W +: DATA_W] = w_data;
   end

   assign Ready = w_ready;

endmodule
